// File: rtl/traffic_light_monitor.sv
// Passive protocol checker for the four-way traffic light buses.
// Tracks the served approach, counts phase/serve lengths and latches the first violation.
module traffic_light_monitor #(
    parameter int unsigned GREEN_MIN     = 4,
    parameter int unsigned GREEN_MAX     = 16,
    parameter int unsigned YELLOW_CYCLES = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       n_lights,
    input  logic [1:0]       s_lights,
    input  logic [1:0]       e_lights,
    input  logic [1:0]       w_lights,
    input  logic             clr_fault,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [1:0]       fault_dir,
    output logic             active_valid,
    output logic [1:0]       active_dir,
    output logic [CNT_W-1:0] phase_cnt,
    output logic [7:0]       serve_count
);

    typedef enum logic [1:0] {ST_ALL_RED, ST_GREEN, ST_YELLOW} state_e;
    typedef enum logic [2:0] {
        F_NONE, F_INVALID, F_CONFLICT, F_ILLEGAL_TRANS,
        F_GREEN_SHORT, F_GREEN_LONG, F_YELLOW_LEN
    } fault_e;

    localparam logic [1:0] RED = 2'b00;
    localparam logic [1:0] YEL = 2'b01;
    localparam logic [1:0] GRN = 2'b10;
    localparam logic [1:0] INV = 2'b11;

    localparam logic [CNT_W-1:0] GREEN_MIN_C = CNT_W'(GREEN_MIN);
    localparam logic [CNT_W-1:0] GREEN_MAX_C = CNT_W'(GREEN_MAX);
    localparam logic [CNT_W-1:0] YELLOW_C    = CNT_W'(YELLOW_CYCLES);
    localparam logic [CNT_W-1:0] CNT_SAT     = '1;

    state_e           state_q, state_d;
    fault_e           fcode_q, fcode_d;
    logic [1:0]       prev_q [4];
    logic [1:0]       prev_d [4];
    logic [1:0]       cur    [4];
    logic [1:0]       adir_q, adir_d, fdir_q, fdir_d;
    logic             avalid_q, avalid_d, fault_q, fault_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [7:0]       serve_q, serve_d;

    logic [2:0]       lit_cnt;
    logic [1:0]       first_lit, inv_dir, ill_dir, idx, a_cur;
    logic             inv_hit, ill_hit, g_short, g_long, y_len, same_phase;
    fault_e           new_code;
    logic [1:0]       new_dir;

    always_comb begin
        cur[0] = n_lights;
        cur[1] = s_lights;
        cur[2] = e_lights;
        cur[3] = w_lights;

        lit_cnt   = '0;
        first_lit = '0;
        inv_hit   = 1'b0;
        inv_dir   = '0;
        ill_hit   = 1'b0;
        ill_dir   = '0;
        idx       = '0;
        // Scan high-to-low so the last match left standing is the lowest index.
        for (int unsigned i = 0; i < 4; i++) begin
            idx = 2'(3 - i);
            prev_d[idx] = cur[idx];
            if (cur[idx] != RED) begin
                lit_cnt   = lit_cnt + 3'd1;
                first_lit = idx;
            end
            if (cur[idx] == INV) begin
                inv_hit = 1'b1;
                inv_dir = idx;
            end
            if ((prev_q[idx] == RED && cur[idx] == YEL) ||
                (prev_q[idx] == YEL && cur[idx] == GRN) ||
                (prev_q[idx] == GRN && cur[idx] == RED)) begin
                ill_hit = 1'b1;
                ill_dir = idx;
            end
        end

        a_cur   = cur[adir_q];
        g_short = (state_q == ST_GREEN) && (a_cur == YEL) && (phase_q < GREEN_MIN_C);
        g_long  = (state_q == ST_GREEN) && (a_cur == GRN) && (phase_q == GREEN_MAX_C);
        y_len   = (state_q == ST_YELLOW) &&
                  (((a_cur == RED) && (phase_q != YELLOW_C)) ||
                   ((a_cur == YEL) && (phase_q == YELLOW_C)));

        new_code = F_NONE;
        new_dir  = '0;
        if (inv_hit) begin
            new_code = F_INVALID;
            new_dir  = inv_dir;
        end else if (lit_cnt > 3'd1) begin
            new_code = F_CONFLICT;
            new_dir  = first_lit;
        end else if (ill_hit) begin
            new_code = F_ILLEGAL_TRANS;
            new_dir  = ill_dir;
        end else if (g_short) begin
            new_code = F_GREEN_SHORT;
            new_dir  = adir_q;
        end else if (g_long) begin
            new_code = F_GREEN_LONG;
            new_dir  = adir_q;
        end else if (y_len) begin
            new_code = F_YELLOW_LEN;
            new_dir  = adir_q;
        end

        // The FSM always resyncs to whatever a lone lit approach shows.
        state_d = ST_ALL_RED;
        if (lit_cnt == 3'd1) begin
            if (cur[first_lit] == GRN) begin
                state_d = ST_GREEN;
            end else if (cur[first_lit] == YEL) begin
                state_d = ST_YELLOW;
            end
        end

        avalid_d   = (lit_cnt == 3'd1);
        adir_d     = avalid_d ? first_lit : adir_q;
        same_phase = (state_d == state_q) && ((state_q == ST_ALL_RED) || (first_lit == adir_q));
        if (!same_phase) begin
            phase_d = CNT_W'(1);
        end else if (phase_q == CNT_SAT) begin
            phase_d = phase_q;
        end else begin
            phase_d = phase_q + CNT_W'(1);
        end
        serve_d = serve_q + 8'((state_q == ST_YELLOW) && (a_cur == RED));

        fault_d = fault_q;
        fcode_d = fcode_q;
        fdir_d  = fdir_q;
        if (clr_fault) begin
            fault_d = 1'b0;
            fcode_d = F_NONE;
            fdir_d  = '0;
        end
        if ((new_code != F_NONE) && !fault_d) begin
            fault_d = 1'b1;
            fcode_d = new_code;
            fdir_d  = new_dir;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_ALL_RED;
            fcode_q  <= F_NONE;
            fault_q  <= 1'b0;
            fdir_q   <= '0;
            adir_q   <= '0;
            avalid_q <= 1'b0;
            phase_q  <= '0;
            serve_q  <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                prev_q[i] <= RED;
            end
        end else begin
            state_q  <= state_d;
            fcode_q  <= fcode_d;
            fault_q  <= fault_d;
            fdir_q   <= fdir_d;
            adir_q   <= adir_d;
            avalid_q <= avalid_d;
            phase_q  <= phase_d;
            serve_q  <= serve_d;
            for (int unsigned i = 0; i < 4; i++) begin
                prev_q[i] <= prev_d[i];
            end
        end
    end

    assign fault        = fault_q;
    assign fault_code   = fcode_q;
    assign fault_dir    = fdir_q;
    assign active_valid = avalid_q;
    assign active_dir   = adir_q;
    assign phase_cnt    = phase_q;
    assign serve_count  = serve_q;

endmodule
